// File: rtl/trb_rw_scheduler.sv
// trb_rw_scheduler: single-port trace-RAM read/write arbiter with burst-limited fairness.
// Define TRB_SCHED_STATS_EN to build the write/read stall counters.
module trb_rw_scheduler #(
   parameter int PTR_W     = 6,
   parameter int MAX_BURST = 4
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   input  logic             WR_REQ_I,
   input  logic             RD_REQ_I,
   input  logic [PTR_W-1:0] WR_PTR_I,
   input  logic [PTR_W-1:0] RD_PTR_I,
   input  logic             OVERWRITE_I,
   output logic             RW_TURN_O,
   output logic             WRITE_ALLOW_O,
   output logic             READ_ALLOW_O,
   output logic             OVERRUN_O,
   output logic [15:0]      WR_STALL_CNT_O,
   output logic [15:0]      RD_STALL_CNT_O
);
   localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2;
   localparam logic [3:0] BURST_TOP = 4'(MAX_BURST - 1);
   logic [1:0]       r_state, w_next;
   logic [3:0]       r_burst;
   logic             r_last_rd;
   logic [PTR_W-1:0] w_wp1, w_wp2, w_rp1;
   logic             w_full, w_can_wr, w_can_rd, w_want_wr, w_want_rd, w_burst_end;
   assign w_wp1       = WR_PTR_I + PTR_W'(1);
   assign w_wp2       = WR_PTR_I + PTR_W'(2);
   assign w_rp1       = RD_PTR_I + PTR_W'(1);
   // In WRITE/READ the granted access is still in flight, so look one slot ahead.
   assign w_full      = (w_wp1 == RD_PTR_I) || (r_state == WRITE && w_wp2 == RD_PTR_I);
   assign w_can_wr    = OVERWRITE_I || !w_full;
   assign w_can_rd    = (RD_PTR_I != WR_PTR_I) && !(r_state == READ && w_rp1 == WR_PTR_I);
   assign w_want_wr   = WR_REQ_I && w_can_wr;
   assign w_want_rd   = RD_REQ_I && w_can_rd;
   assign w_burst_end = r_burst == BURST_TOP;
   assign w_next = (r_state == WRITE) ? ((w_want_rd && w_burst_end) ? READ : w_want_wr ? WRITE : w_want_rd ? READ : IDLE)
                 : (r_state == READ)  ? ((w_want_wr && w_burst_end) ? WRITE : w_want_rd ? READ : w_want_wr ? WRITE : IDLE)
                 : (w_want_wr && w_want_rd) ? (r_last_rd ? WRITE : READ)
                 : w_want_wr ? WRITE : w_want_rd ? READ : IDLE;
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_state       <= IDLE;
         r_burst       <= '0;
         r_last_rd     <= 1'b1;
         WRITE_ALLOW_O <= 1'b0;
         READ_ALLOW_O  <= 1'b0;
         RW_TURN_O     <= 1'b0;
         OVERRUN_O     <= 1'b0;
      end else begin
         r_state       <= w_next;
         WRITE_ALLOW_O <= w_next == WRITE;
         READ_ALLOW_O  <= w_next == READ;
         OVERRUN_O     <= WR_REQ_I && !OVERWRITE_I && w_full;
         if (w_next != IDLE) begin
            RW_TURN_O <= w_next == READ;
            r_last_rd <= w_next == READ;
            r_burst   <= ((w_next == READ) != r_last_rd) ? 4'd0 : w_burst_end ? r_burst : r_burst + 4'd1;
         end
      end
   end
`ifdef TRB_SCHED_STATS_EN
   logic [15:0] r_wr_stall, r_rd_stall;
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_wr_stall <= '0;
         r_rd_stall <= '0;
      end else begin
         if (WR_REQ_I && w_next != WRITE && r_wr_stall != 16'hFFFF) r_wr_stall <= r_wr_stall + 16'd1;
         if (RD_REQ_I && w_can_rd && w_next != READ && r_rd_stall != 16'hFFFF) r_rd_stall <= r_rd_stall + 16'd1;
      end
   end
   assign WR_STALL_CNT_O = r_wr_stall;
   assign RD_STALL_CNT_O = r_rd_stall;
`else
   assign WR_STALL_CNT_O = 16'd0;
   assign RD_STALL_CNT_O = 16'd0;
`endif
endmodule

// File: tb/tb_trb_rw_scheduler.sv
// tb_trb_rw_scheduler: directed and random checks of trb_rw_scheduler against a grant-level model.
module tb_trb_rw_scheduler;
   localparam int MAXB = 4;
   logic        clk = 1'b0;
   logic        rst = 1'b1, wr = 1'b0, rd = 1'b0, ov = 1'b0;
   logic [2:0]  wp = '0, rp = '0;
   logic        turn, wa, ra, ovr;
   logic [15:0] wst, rst_cnt;
   int tests = 0, fails = 0;
   int m_st, m_run, m_last, m_turn, m_ovr, m_wst, m_rst;
   bit track = 0;
   int wgrants;
   int pat [9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};

   trb_rw_scheduler #(.PTR_W(3), .MAX_BURST(MAXB)) dut (
      .CLK_I(clk), .RST_I(rst), .WR_REQ_I(wr), .RD_REQ_I(rd),
      .WR_PTR_I(wp), .RD_PTR_I(rp), .OVERWRITE_I(ov),
      .RW_TURN_O(turn), .WRITE_ALLOW_O(wa), .READ_ALLOW_O(ra), .OVERRUN_O(ovr),
      .WR_STALL_CNT_O(wst), .RD_STALL_CNT_O(rst_cnt)
   );

   always #5 clk = ~clk;

   // Model state: m_st 0=idle 1=write 2=read; m_run = grants in a row to side m_last.
   task automatic model_edge();
      int dw, dr, nxt;
      bit full, cw, cr, ww, wrd;
      if (rst) begin
         m_st = 0; m_run = 1; m_last = 2; m_turn = 0; m_ovr = 0; m_wst = 0; m_rst = 0;
         return;
      end
      dw   = (int'(rp) - int'(wp)) & 7;
      dr   = (int'(wp) - int'(rp)) & 7;
      full = (m_st == 1) ? (dw == 1 || dw == 2) : (dw == 1);
      cw   = ov || !full;
      cr   = (m_st == 2) ? (dr >= 2) : (dr >= 1);
      ww   = wr && cw;
      wrd  = rd && cr;
      if (ww && wrd) nxt = (m_st == 0) ? (m_last == 2 ? 1 : 2) : (m_run >= MAXB ? 3 - m_st : m_st);
      else nxt = ww ? 1 : wrd ? 2 : 0;
      m_ovr = (wr && !ov && full) ? 1 : 0;
`ifdef TRB_SCHED_STATS_EN
      if (wr && nxt != 1 && m_wst < 65535) m_wst++;
      if (rd && cr && nxt != 2 && m_rst < 65535) m_rst++;
`endif
      if (nxt != 0) begin
         m_run  = (nxt == m_last) ? m_run + 1 : 1;
         m_last = nxt;
         m_turn = (nxt == 2) ? 1 : 0;
      end
      m_st = nxt;
   endtask

   task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("write_allow", 16'(wa), 16'(m_st == 1));
      chk("read_allow", 16'(ra), 16'(m_st == 2));
      chk("rw_turn", 16'(turn), 16'(m_turn));
      chk("overrun", 16'(ovr), 16'(m_ovr));
      chk("wr_stall", wst, 16'(m_wst));
      chk("rd_stall", rst_cnt, 16'(m_rst));
      chk("exclusive", 16'(wa & ra), 16'd0);
      if (track && m_st == 1) wp = wp + 3'd1;
      if (track && m_st == 2) rp = rp + 3'd1;
   endtask

   initial begin
      rst = 1; step(); step();
      chk("reset_outputs", {12'd0, turn, wa, ra, ovr}, 16'd0);
      // Both sides eligible, fixed pointers: bursts of MAXB alternate, writer first.
      wr = 1; rd = 1; wp = 3'd0; rp = 3'd4; rst = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         chk("burst_seq", {14'd0, ra, wa}, 16'(pat[i]));
      end
      // Write into a full buffer without overwrite.
      rst = 1; wr = 0; rd = 0; step();
      rst = 0; wr = 1; wp = 3'd6; rp = 3'd0; ov = 0; track = 1; wgrants = 0;
      step(); wgrants += int'(wa);
      chk("first_write", 16'(wa), 16'd1);
      step(); wgrants += int'(wa);
      chk("overrun_pulse", 16'(ovr), 16'd1);
      for (int i = 0; i < 4; i++) begin step(); wgrants += int'(wa); end
      chk("write_grant_count", 16'(wgrants), 16'd1);
      // Ring-buffer mode: writes never refused.
      rst = 1; step();
      rst = 0; wp = 3'd6; rp = 3'd0; ov = 1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("ring_write", 16'(wa), 16'd1);
         chk("ring_no_overrun", 16'(ovr), 16'd0);
      end
      // Empty buffer: read request neither granted nor counted.
      rst = 1; step();
      rst = 0; track = 0; wr = 0; rd = 1; ov = 0; wp = 3'd5; rp = 3'd5;
      for (int i = 0; i < 4; i++) step();
      chk("empty_no_read", 16'(ra), 16'd0);
      chk("empty_no_rd_stall", rst_cnt, 16'd0);
      // Reset in the middle of a read burst.
      wp = 3'd4; rp = 3'd0; step(); step();
      chk("read_burst", 16'(ra), 16'd1);
      rst = 1; step();
      chk("reset_kills_read", 16'(ra), 16'd0);
      chk("reset_counters", wst | rst_cnt, 16'd0);
      rst = 0;
      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         wr  = 1'($urandom);
         rd  = 1'($urandom);
         ov  = ($urandom_range(0, 3) == 0);
         wp  = 3'($urandom);
         rp  = wp + 3'($urandom_range(0, 3));
         step();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
